// File: rtl/sm4_key_expansion_if.sv
// Round-key interface between the SM4 key schedule (slave) and its controller/consumer (master).
`default_nettype none

interface sm4_key_expansion_if;
  logic [127:0] key;
  logic         start;
  logic         busy;
  logic         key_ready;
  logic         rk_valid;
  logic [4:0]   rk_idx;
  logic [31:0]  rk_data;
  logic [4:0]   rd_idx;
  logic         rd_dir;
  logic [31:0]  rd_rk;

  modport master (
    output key, start, rd_idx, rd_dir,
    input  busy, key_ready, rk_valid, rk_idx, rk_data, rd_rk
  );

  modport slave (
    input  key, start, rd_idx, rd_dir,
    output busy, key_ready, rk_valid, rk_idx, rk_data, rd_rk
  );
endinterface

`default_nettype wire

// File: rtl/sm4_key_expansion.sv
// sm4_key_expansion: iterative SM4 key schedule, two cycles per round key, with a 32x32 key store
// and a registered forward/reverse read port. Rev 1.0.
`default_nettype none

module sm4_key_expansion #(
  parameter int NUM_ROUNDS = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sm4_key_expansion_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] XOR  = 2'd2;
  localparam logic [1:0] SUB  = 2'd3;

  localparam logic [4:0]   LAST_RND = 5'(NUM_ROUNDS - 1);
  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] l_prime(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  logic [1:0]   state;
  logic [1:0]   state_next;
  logic [127:0] mk;
  logic [31:0]  k0, k1, k2, k3, t;
  logic [4:0]   rnd;
  logic [31:0]  store [NUM_ROUNDS];
  logic         busy, key_ready, rk_valid;
  logic [4:0]   rk_idx;
  logic [31:0]  rk_data, rd_rk;
  logic [7:0]   ck_base;
  logic [31:0]  ck, rk_new;
  logic [4:0]   rd_addr;

  // CK byte j of round r is ((4r + j) * 7) mod 256; 8-bit arithmetic gives the modulo for free.
  always_comb begin
    ck_base = {1'b0, rnd, 2'b00};
    ck      = {ck_base * 8'd7, (ck_base + 8'd1) * 8'd7,
               (ck_base + 8'd2) * 8'd7, (ck_base + 8'd3) * 8'd7};
    rk_new  = k0 ^ l_prime(tau(t));
    rd_addr = bus.rd_dir ? ~bus.rd_idx : bus.rd_idx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    state_next = XOR;
      XOR:     state_next = SUB;
      SUB:     state_next = (rnd == LAST_RND) ? IDLE : XOR;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mk        <= '0;
      k0        <= '0;
      k1        <= '0;
      k2        <= '0;
      k3        <= '0;
      t         <= '0;
      rnd       <= '0;
      key_ready <= 1'b0;
      rk_valid  <= 1'b0;
      rk_idx    <= '0;
      rk_data   <= '0;
    end else begin
      rk_valid <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          mk        <= bus.key;
          key_ready <= 1'b0;
        end
        LOAD: begin
          {k0, k1, k2, k3} <= mk ^ FK;
          rnd              <= '0;
        end
        XOR: t <= k1 ^ k2 ^ k3 ^ ck;
        SUB: begin
          {k0, k1, k2, k3} <= {k1, k2, k3, rk_new};
          rk_valid         <= 1'b1;
          rk_idx           <= rnd;
          rk_data          <= rk_new;
          if (rnd == LAST_RND) key_ready <= 1'b1;
          else                 rnd       <= rnd + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Write and read share an edge, so a same-entry read returns the pre-write value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_ROUNDS; i++) store[i] <= '0;
      rd_rk <= '0;
    end else begin
      if (state == SUB) store[rnd] <= rk_new;
      rd_rk <= store[rd_addr];
    end
  end

  assign bus.busy      = busy;
  assign bus.key_ready = key_ready;
  assign bus.rk_valid  = rk_valid;
  assign bus.rk_idx    = rk_idx;
  assign bus.rk_data   = rk_data;
  assign bus.rd_rk     = rd_rk;

endmodule

`default_nettype wire
